// File: rtl/gpr_write_arbiter.sv
// ============================================================================
// Module   : gpr_write_arbiter
// Purpose  : Shares the GPR write port between the in-order write-back path
//            and a buffered long-latency (mul/div) result stream.
//            Optional macro GPR_ARB_PERF_EN adds stall/drop counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int BUF_DEPTH     = 2,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wb_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    wb_wdata_i,
  output logic                     wb_stall_o,
  input  logic                     mc_valid_i,
  output logic                     mc_ready_o,
  input  logic [RF_ADDR_WIDTH-1:0] mc_rd_i,
  input  logic [DATA_WIDTH-1:0]    mc_wdata_i,
  output logic                     gpr_we_o,
  output logic [RF_ADDR_WIDTH-1:0] gpr_waddr_o,
  output logic [DATA_WIDTH-1:0]    gpr_wdata_o
`ifdef GPR_ARB_PERF_EN
  ,
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              drop_cnt_o
`endif
);

  localparam int c_PTR_W = $clog2(BUF_DEPTH);
  localparam int c_AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    S_PIPE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                     r_state;
  logic                       r_stall;
  logic                       r_mc_ready;
  logic [c_PTR_W:0]           r_wptr;
  logic [c_PTR_W:0]           r_rptr;
  logic [c_AGE_W-1:0]         r_age;
  logic                       r_gpr_we;
  logic [RF_ADDR_WIDTH-1:0]   r_gpr_waddr;
  logic [DATA_WIDTH-1:0]      r_gpr_wdata;
  logic [RF_ADDR_WIDTH-1:0]   r_mem_rd   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]      r_mem_data [BUF_DEPTH];

  logic                       w_wb_req;
  logic                       w_mc_acc;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_grant_wb;
  logic                       w_empty;
  logic                       w_empty_nxt;
  logic                       w_full_nxt;
  logic [c_PTR_W:0]           w_wptr_nxt;
  logic [c_PTR_W:0]           w_rptr_nxt;
  logic [c_AGE_W-1:0]         w_age_nxt;
  state_t                     w_state_nxt;
  logic [RF_ADDR_WIDTH-1:0]   w_head_rd;
  logic [DATA_WIDTH-1:0]      w_head_data;

  always_comb begin
    w_wb_req    = wb_valid_i && (wb_rd_i != '0);
    w_mc_acc    = mc_valid_i && r_mc_ready;
    // x0 results complete the handshake but never reach the buffer
    w_push      = w_mc_acc && (mc_rd_i != '0);
    w_empty     = (r_wptr == r_rptr);
    w_head_rd   = r_mem_rd[r_rptr[c_PTR_W-1:0]];
    w_head_data = r_mem_data[r_rptr[c_PTR_W-1:0]];

    w_pop      = 1'b0;
    w_grant_wb = 1'b0;
    if (r_state == S_DRAIN) begin
      w_pop = !w_empty;
    end else if (w_wb_req) begin
      w_grant_wb = 1'b1;
    end else begin
      w_pop = !w_empty;
    end

    w_wptr_nxt  = r_wptr + (c_PTR_W+1)'(w_push);
    w_rptr_nxt  = r_rptr + (c_PTR_W+1)'(w_pop);
    w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
    w_full_nxt  = (w_wptr_nxt[c_PTR_W] != w_rptr_nxt[c_PTR_W]) &&
                  (w_wptr_nxt[c_PTR_W-1:0] == w_rptr_nxt[c_PTR_W-1:0]);

    w_age_nxt = '0;
    if (!w_empty && !w_pop) begin
      w_age_nxt = (r_age == c_AGE_MAX) ? r_age : r_age + c_AGE_W'(1);
    end

    w_state_nxt = r_state;
    if (r_state == S_PIPE) begin
      if (w_full_nxt || (w_age_nxt == c_AGE_MAX)) begin
        w_state_nxt = S_DRAIN;
      end
    end else if (w_empty_nxt) begin
      w_state_nxt = S_PIPE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_PIPE;
      r_stall     <= 1'b0;
      r_mc_ready  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_age       <= '0;
      r_gpr_we    <= 1'b0;
      r_gpr_waddr <= '0;
      r_gpr_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stall    <= (w_state_nxt == S_DRAIN);
      r_mc_ready <= !w_full_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_age      <= w_age_nxt;
      r_gpr_we   <= w_grant_wb || w_pop;
      if (w_grant_wb) begin
        r_gpr_waddr <= wb_rd_i;
        r_gpr_wdata <= wb_wdata_i;
      end else if (w_pop) begin
        r_gpr_waddr <= w_head_rd;
        r_gpr_wdata <= w_head_data;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_rd[w_wptr_nxt[c_PTR_W-1:0] - c_PTR_W'(1)]   <= mc_rd_i;
      r_mem_data[w_wptr_nxt[c_PTR_W-1:0] - c_PTR_W'(1)] <= mc_wdata_i;
    end
  end

`ifdef GPR_ARB_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'(1);
      end
      if (w_mc_acc && (mc_rd_i == '0) && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 32'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`endif

  assign wb_stall_o  = r_stall;
  assign mc_ready_o  = r_mc_ready;
  assign gpr_we_o    = r_gpr_we;
  assign gpr_waddr_o = r_gpr_waddr;
  assign gpr_wdata_o = r_gpr_wdata;

endmodule

`default_nettype wire
